// File: rtl/conv_window_shifter.sv
// K_H x K_W sliding-window register. It shifts in one column per handshake, inserts the
// zero-pad columns by itself, applies the stride and presents each window over valid/ready.
module conv_window_shifter #(
   parameter int unsigned DW     = 8,
   parameter int unsigned K_H    = 3,
   parameter int unsigned K_W    = 3,
   parameter int unsigned IMG_W  = 32,
   parameter int unsigned STRIDE = 1,
   parameter int unsigned PAD    = 0,
   localparam int unsigned W_P   = IMG_W + 2 * PAD,
   localparam int unsigned OUT_W = (W_P - K_W) / STRIDE + 1,
   localparam int unsigned CW    = ($clog2(W_P) > 0) ? $clog2(W_P) : 1,
   localparam int unsigned OW    = ($clog2(OUT_W) > 0) ? $clog2(OUT_W) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear_i,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [K_H-1:0][DW-1:0]              in_col_i,
   output logic                                win_valid_o,
   input  logic                                win_ready_i,
   output logic [K_H-1:0][K_W-1:0][DW-1:0]     window_o,
   output logic [OW-1:0]                       win_col_idx_o,
   output logic                                row_done_o
);

   localparam int unsigned PW = ($clog2(STRIDE) > 0) ? $clog2(STRIDE) : 1;

   logic [K_H-1:0][K_W-1:0][DW-1:0] win_q, win_d;
   logic [CW-1:0] p_q, p_d;
   logic [OW-1:0] oc_q, oc_d, idx_q, idx_d;
   logic [PW-1:0] ph_q, ph_d;
   logic          valid_q, valid_d, row_done_q, row_done_d;
   logic          pad_lo, pad_hi, pad_col, past_fill;
   logic          can_shift, shift, at_last, emit;

   if (PAD > 0) begin : g_pad_lo
      assign pad_lo = p_q < CW'(PAD);
   end else begin : g_no_pad_lo
      assign pad_lo = 1'b0;
   end

   if (K_W > 1) begin : g_fill
      assign past_fill = {1'b0, p_q} >= (CW+1)'(K_W - 1);
   end else begin : g_no_fill
      assign past_fill = 1'b1;
   end

   assign pad_hi    = {1'b0, p_q} >= (CW+1)'(PAD + IMG_W);
   assign pad_col   = pad_lo || pad_hi;
   assign can_shift = !valid_q || win_ready_i;
   assign shift     = can_shift && (pad_col || in_valid_i);
   assign at_last   = p_q == CW'(W_P - 1);
   // ph_q counts shifts since the last window-completing column of this row.
   assign emit      = past_fill && (ph_q == '0);

   assign in_ready_o = rst_n && !clear_i && can_shift && !pad_col;

   always_comb begin
      win_d      = win_q;
      p_d        = p_q;
      oc_d       = oc_q;
      idx_d      = idx_q;
      ph_d       = ph_q;
      valid_d    = valid_q;
      row_done_d = 1'b0;
      if (valid_q && win_ready_i) valid_d = 1'b0;
      if (shift) begin
         for (int i = 0; i < K_H; i++) begin
            for (int j = K_W - 1; j >= 1; j--) win_d[i][j] = win_q[i][j-1];
            win_d[i][0] = pad_col ? '0 : in_col_i[i];
         end
         p_d     = at_last ? '0 : p_q + 1'b1;
         valid_d = emit;
         if (emit) begin
            idx_d = oc_q;
            oc_d  = (oc_q == OW'(OUT_W - 1)) ? '0 : oc_q + 1'b1;
         end
         if (past_fill) ph_d = (ph_q == PW'(STRIDE - 1)) ? '0 : ph_q + 1'b1;
         if (at_last) begin
            row_done_d = 1'b1;
            oc_d       = '0;
            ph_d       = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         win_q      <= '0;
         p_q        <= '0;
         oc_q       <= '0;
         idx_q      <= '0;
         ph_q       <= '0;
         valid_q    <= 1'b0;
         row_done_q <= 1'b0;
      end else begin
         win_q      <= win_d;
         p_q        <= p_d;
         oc_q       <= oc_d;
         idx_q      <= idx_d;
         ph_q       <= ph_d;
         valid_q    <= valid_d;
         row_done_q <= row_done_d;
      end
   end

   assign window_o      = win_q;
   assign win_valid_o   = valid_q;
   assign win_col_idx_o = idx_q;
   assign row_done_o    = row_done_q;

endmodule

// File: tb/tb_conv_window_shifter.sv
// Directed bench for conv_window_shifter: three instances cover the plain, padded and
// strided configurations; column i of row value v carries v + 16*i.
module tb_conv_window_shifter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int nwin;

   // a: IMG_W=5 PAD=0 S=1
   logic                  clear_a, in_valid_a, in_ready_a, win_valid_a, win_ready_a, row_done_a;
   logic [2:0][7:0]       in_col_a;
   logic [2:0][2:0][7:0]  window_a;
   logic [1:0]            idx_a;
   // b: IMG_W=5 PAD=1 S=1
   logic                  clear_b, in_valid_b, in_ready_b, win_valid_b, win_ready_b, row_done_b;
   logic [2:0][7:0]       in_col_b;
   logic [2:0][2:0][7:0]  window_b;
   logic [2:0]            idx_b;
   // c: IMG_W=6 PAD=0 S=2
   logic                  clear_c, in_valid_c, in_ready_c, win_valid_c, win_ready_c, row_done_c;
   logic [2:0][7:0]       in_col_c;
   logic [2:0][2:0][7:0]  window_c;
   logic [0:0]            idx_c;

   conv_window_shifter #(.DW(8), .K_H(3), .K_W(3), .IMG_W(5), .STRIDE(1), .PAD(0)) u_a (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .in_valid_i(in_valid_a),
      .in_ready_o(in_ready_a), .in_col_i(in_col_a), .win_valid_o(win_valid_a),
      .win_ready_i(win_ready_a), .window_o(window_a), .win_col_idx_o(idx_a),
      .row_done_o(row_done_a));

   conv_window_shifter #(.DW(8), .K_H(3), .K_W(3), .IMG_W(5), .STRIDE(1), .PAD(1)) u_b (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_b), .in_valid_i(in_valid_b),
      .in_ready_o(in_ready_b), .in_col_i(in_col_b), .win_valid_o(win_valid_b),
      .win_ready_i(win_ready_b), .window_o(window_b), .win_col_idx_o(idx_b),
      .row_done_o(row_done_b));

   conv_window_shifter #(.DW(8), .K_H(3), .K_W(3), .IMG_W(6), .STRIDE(2), .PAD(0)) u_c (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_c), .in_valid_i(in_valid_c),
      .in_ready_o(in_ready_c), .in_col_i(in_col_c), .win_valid_o(win_valid_c),
      .win_ready_i(win_ready_c), .window_o(window_c), .win_col_idx_o(idx_c),
      .row_done_o(row_done_c));

   function automatic logic [23:0] colv(input int v);
      logic [23:0] c;
      for (int i = 0; i < 3; i++) c[i*8 +: 8] = 8'(v + 16 * i);
      return c;
   endfunction

   // Expected window from column values newest..oldest; 0 stands for a pad column.
   function automatic logic [71:0] ew(input int a0, input int a1, input int a2);
      logic [71:0] w;
      int          a[3];
      a[0] = a0; a[1] = a1; a[2] = a2;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(i*3 + j)*8 +: 8] = (a[j] == 0) ? 8'd0 : 8'(a[j] + 16 * i);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic row_a(input int base);
      for (int k = 1; k <= 5; k++) begin
         in_valid_a  = 1'b1;
         in_col_a    = colv(base + k);
         win_ready_a = 1'b1;
         #1;
         chk("a_in_ready", 128'(in_ready_a), 128'(1));
         tick();
         if (win_valid_a === 1'b1) nwin++;
         chk("a_valid", 128'(win_valid_a), 128'(k >= 3));
         if (k >= 3) begin
            chk("a_idx", 128'(idx_a), 128'(k - 3));
            chk("a_window", 128'(window_a), 128'(ew(base + k, base + k - 1, base + k - 2)));
         end
         chk("a_row_done", 128'(row_done_a), 128'(k == 5));
      end
      in_valid_a = 1'b0;
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_valid"}, 128'(win_valid_a), 128'(0));
      chk({tag, "_idx"}, 128'(idx_a), 128'(0));
      chk({tag, "_window"}, 128'(window_a), 128'(0));
      chk({tag, "_row_done"}, 128'(row_done_a), 128'(0));
   endtask

   int hist_b[8]  = '{0, 1, 2, 3, 4, 5, 0, 0};
   int pres_b[8]  = '{1, 1, 2, 3, 4, 5, 1, 1};
   int rdy_b[8]   = '{0, 1, 1, 1, 1, 1, 0, 0};
   int vld_b[8]   = '{0, 0, 1, 1, 1, 1, 1, 0};
   int vld_c[6]   = '{0, 0, 1, 0, 1, 0};
   int idx_ce[6]  = '{0, 0, 0, 0, 1, 0};

   initial begin
      rst_n = 1'b0;
      clear_a = 1'b0; in_valid_a = 1'b1; in_col_a = colv(9); win_ready_a = 1'b1;
      clear_b = 1'b1; in_valid_b = 1'b0; in_col_b = '0;      win_ready_b = 1'b1;
      clear_c = 1'b0; in_valid_c = 1'b0; in_col_c = '0;      win_ready_c = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready_a), 128'(0));
      tick();
      chk_a_zero("rst");
      in_valid_a = 1'b0;
      rst_n = 1'b1;

      // Single row, full throughput
      row_a(0);
      tick();
      chk("t1_idle_valid", 128'(win_valid_a), 128'(0));
      chk("t1_row_done_pulse", 128'(row_done_a), 128'(0));

      // Backpressure on the first window
      for (int k = 1; k <= 3; k++) begin
         in_valid_a = 1'b1; in_col_a = colv(k); tick();
      end
      chk("t2_first_valid", 128'(win_valid_a), 128'(1));
      win_ready_a = 1'b0;
      in_col_a = colv(4);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_stall_in_ready", 128'(in_ready_a), 128'(0));
         tick();
         chk("t2_stall_valid", 128'(win_valid_a), 128'(1));
         chk("t2_stall_idx", 128'(idx_a), 128'(0));
         chk("t2_stall_window", 128'(window_a), 128'(ew(3, 2, 1)));
      end
      win_ready_a = 1'b1;
      #1;
      chk("t2_resume_in_ready", 128'(in_ready_a), 128'(1));
      tick();
      chk("t2_idx1", 128'(idx_a), 128'(1));
      chk("t2_win1", 128'(window_a), 128'(ew(4, 3, 2)));
      in_col_a = colv(5);
      tick();
      chk("t2_idx2", 128'(idx_a), 128'(2));
      chk("t2_win2", 128'(window_a), 128'(ew(5, 4, 3)));
      chk("t2_row_done", 128'(row_done_a), 128'(1));
      in_valid_a = 1'b0;
      tick();
      chk("t2_idle_valid", 128'(win_valid_a), 128'(0));

      // Two rows back to back
      nwin = 0;
      row_a(0);
      row_a(10);
      chk("t6_window_count", 128'(nwin), 128'(6));
      tick();

      // Padded row: pad columns shift on their own
      clear_b = 1'b0;
      in_valid_b = 1'b1;
      for (int s = 0; s < 8; s++) begin
         in_col_b = colv(pres_b[s]);
         #1;
         chk("t3_in_ready", 128'(in_ready_b), 128'(rdy_b[s]));
         tick();
         chk("t3_valid", 128'(win_valid_b), 128'(vld_b[s]));
         if (vld_b[s] != 0) begin
            chk("t3_idx", 128'(idx_b), 128'(s - 2));
            chk("t3_window", 128'(window_b), 128'(ew(hist_b[s], hist_b[s-1], hist_b[s-2])));
         end
         chk("t3_row_done", 128'(row_done_b), 128'(s == 6));
      end
      in_valid_b = 1'b0;

      // Stride 2 with a trailing column
      in_valid_c = 1'b1;
      for (int s = 0; s < 6; s++) begin
         in_col_c = colv(s + 1);
         #1;
         chk("t4_in_ready", 128'(in_ready_c), 128'(1));
         tick();
         chk("t4_valid", 128'(win_valid_c), 128'(vld_c[s]));
         if (vld_c[s] != 0) begin
            chk("t4_idx", 128'(idx_c), 128'(idx_ce[s]));
            chk("t4_window", 128'(window_c), 128'(ew(s + 1, s, s - 1)));
         end
         chk("t4_row_done", 128'(row_done_c), 128'(s == 5));
      end
      in_valid_c = 1'b0;

      // Reset mid-row with a column offered
      for (int k = 1; k <= 2; k++) begin
         in_valid_a = 1'b1; in_col_a = colv(k); tick();
      end
      rst_n = 1'b0;
      in_col_a = colv(3);
      #1;
      chk("t5_rst_in_ready", 128'(in_ready_a), 128'(0));
      tick();
      chk_a_zero("t5_rst");
      rst_n = 1'b1;
      row_a(0);
      tick();

      // Clear mid-row while a window is presented
      for (int k = 1; k <= 3; k++) begin
         in_valid_a = 1'b1; in_col_a = colv(k); tick();
      end
      chk("t5_pre_clear_valid", 128'(win_valid_a), 128'(1));
      clear_a = 1'b1;
      in_col_a = colv(4);
      #1;
      chk("t5_clr_in_ready", 128'(in_ready_a), 128'(0));
      tick();
      chk_a_zero("t5_clr");
      clear_a = 1'b0;
      row_a(0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
